// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor counter types, constants and saturating update
package bp_pkg;
  localparam int BP_CNT_W = 2;
  localparam int BP_INIT_VAL = 1;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  function automatic logic [BP_CNT_W-1:0] sat_update(input logic [BP_CNT_W-1:0] old, input logic taken);
    return taken ? ((&old) ? old : old + 1'b1) : ((old == '0) ? old : old - 1'b1);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, favours the source not granted last
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_grant0,
  output logic o_grant1
);
  logic r_rr_last;
  assign o_grant0 = i_en & i_valid0 & (~i_valid1 | r_rr_last);
  assign o_grant1 = i_en & i_valid1 & (~i_valid0 | ~r_rr_last);
  // remember the last winner; reset value 1 lets source 0 win first
  always_ff @(posedge clk)
    if (reset) r_rr_last <= 1'b1;
    else if (o_grant0 | o_grant1) r_rr_last <= o_grant1;
endmodule

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: init sweep plus arbitrated read-modify-write of BHT counters
module bht_update_ctrl
  import bp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int CNT_W = BP_CNT_W,
  parameter int INIT_VAL = BP_INIT_VAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_idx,
  input  logic              req0_taken,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_idx,
  input  logic              req1_taken,
  output logic [ADDR_W-1:0] tbl_raddr,
  input  logic [CNT_W-1:0]  tbl_rdata,
  output logic              tbl_we,
  output logic [ADDR_W-1:0] tbl_waddr,
  output logic [CNT_W-1:0]  tbl_wdata,
  output logic              init_done
);
  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_cnt;
  logic               r_s1_v;
  logic [ADDR_W-1:0]  r_s1_addr;
  logic [CNT_W-1:0]   r_s1_data;
  logic               w_run, w_grant, w_taken;
  logic [CNT_W-1:0]   w_old, w_new;
  assign w_run = (r_state == ST_RUN) & ~reset;
  assign init_done = w_run;
  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_run),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .o_grant0 (req0_ready),
    .o_grant1 (req1_ready)
  );
  assign w_grant = req0_ready | req1_ready;
  assign tbl_raddr = req1_ready ? req1_idx : req0_idx;
  assign w_taken = req1_ready ? req1_taken : req0_taken;
  assign w_old = (r_s1_v && r_s1_addr == tbl_raddr) ? r_s1_data : tbl_rdata;
  assign w_new = sat_update(w_old, w_taken);
  // state register
  always_ff @(posedge clk)
    if (reset) r_state <= ST_INIT;
    else r_state <= w_state_nxt;
  // next state and write port: sweep writes in INIT, S1 writes in RUN, nothing under reset
  always_comb begin
    w_state_nxt = (r_state == ST_INIT && r_cnt == ADDR_W'(DEPTH - 1)) ? ST_RUN : r_state;
    tbl_we = ~reset & ((r_state == ST_INIT) | r_s1_v);
    tbl_waddr = reset ? '0 : (r_state == ST_INIT) ? r_cnt : r_s1_addr;
    tbl_wdata = reset ? '0 : (r_state == ST_INIT) ? CNT_W'(INIT_VAL) : r_s1_data;
  end
  // sweep counter and the S1 write-back register
  always_ff @(posedge clk)
    if (reset) begin
      r_cnt <= '0;
      r_s1_v <= 1'b0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
    end else begin
      if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
      r_s1_v <= w_grant;
      if (w_grant) begin
        r_s1_addr <= tbl_raddr;
        r_s1_data <= w_new;
      end
    end
endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb_bht_update_ctrl: directed vector bench with a behavioural counter table
module tb_bht_update_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_taken = 1'b0, req1_taken = 1'b0;
  logic [7:0] req0_idx = '0, req1_idx = '0;
  logic       req0_ready, req1_ready, tbl_we, init_done;
  logic [7:0] tbl_raddr, tbl_waddr;
  logic [1:0] tbl_rdata, tbl_wdata;
  logic [1:0] mem [256];
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       v0;
    logic [7:0] i0;
    logic       t0;
    logic       v1;
    logic [7:0] i1;
    logic       t1;
    logic       r0;
    logic       r1;
    logic       we;
    logic [7:0] wa;
    logic [1:0] wd;
    logic [7:0] ra;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  bht_update_ctrl dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_idx(req0_idx), .req0_taken(req0_taken),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_idx(req1_idx), .req1_taken(req1_taken),
    .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata), .init_done(init_done)
  );

  assign tbl_rdata = mem[tbl_raddr];
  always @(posedge clk) if (tbl_we) mem[tbl_waddr] <= tbl_wdata;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int v0, input int i0, input int t0, input int v1, input int i1, input int t1,
                     input int r0, input int r1, input int we, input int wa, input int wd, input int ra);
    vec_t v;
    v.v0 = v0[0]; v.i0 = i0[7:0]; v.t0 = t0[0];
    v.v1 = v1[0]; v.i1 = i1[7:0]; v.t1 = t1[0];
    v.r0 = r0[0]; v.r1 = r1[0]; v.we = we[0];
    v.wa = wa[7:0]; v.wd = wd[1:0]; v.ra = ra[7:0];
    vecs.push_back(v);
  endtask

  task automatic sweep();
    req0_valid = 1'b1; req1_valid = 1'b1; req0_idx = 8'hAA; req1_idx = 8'h55;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      chk($sformatf("sweep_we[%0d]", k), int'(tbl_we), 1);
      chk($sformatf("sweep_waddr[%0d]", k), int'(tbl_waddr), k);
      chk($sformatf("sweep_wdata[%0d]", k), int'(tbl_wdata), 1);
      chk($sformatf("sweep_done[%0d]", k), int'(init_done), 0);
      chk($sformatf("sweep_rdy[%0d]", k), int'({req0_ready, req1_ready}), 0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    add(1,5,1, 0,0,0, 1,0,0,0,0,5);
    add(1,5,1, 0,0,0, 1,0,1,5,2,5);
    add(1,5,1, 0,0,0, 1,0,1,5,3,5);
    add(1,5,1, 0,0,0, 1,0,1,5,3,5);
    add(0,0,0, 0,0,0, 0,0,1,5,3,0);
    add(1,9,0, 0,0,0, 1,0,0,0,0,9);
    add(1,9,0, 0,0,0, 1,0,1,9,0,9);
    add(0,0,0, 0,0,0, 0,0,1,9,0,0);
    add(0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(1,7,1, 0,0,0, 1,0,0,0,0,7);
    add(1,7,1, 0,0,0, 1,0,1,7,2,7);
    add(0,0,0, 0,0,0, 0,0,1,7,3,0);
    add(1,3,1, 1,4,1, 0,1,0,0,0,4);
    add(1,3,1, 1,4,1, 1,0,1,4,2,3);
    add(1,3,1, 1,4,1, 0,1,1,3,2,4);
    add(1,3,1, 1,4,1, 1,0,1,4,3,3);
    add(0,0,0, 1,4,0, 0,1,1,3,3,4);
    add(0,0,0, 1,4,0, 0,1,1,4,2,4);
    add(0,0,0, 0,0,0, 0,0,1,4,1,0);
    add(0,0,0, 0,0,0, 0,0,0,0,0,0);

    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_we", int'(tbl_we), 0);
    chk("rst_waddr", int'(tbl_waddr), 0);
    chk("rst_wdata", int'(tbl_wdata), 0);
    chk("rst_done", int'(init_done), 0);
    chk("rst_rdy", int'({req0_ready, req1_ready}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sweep();

    foreach (vecs[n]) begin
      req0_valid = vecs[n].v0; req0_idx = vecs[n].i0; req0_taken = vecs[n].t0;
      req1_valid = vecs[n].v1; req1_idx = vecs[n].i1; req1_taken = vecs[n].t1;
      @(negedge clk);
      chk($sformatf("v%0d_done", n), int'(init_done), 1);
      chk($sformatf("v%0d_rdy0", n), int'(req0_ready), int'(vecs[n].r0));
      chk($sformatf("v%0d_rdy1", n), int'(req1_ready), int'(vecs[n].r1));
      chk($sformatf("v%0d_raddr", n), int'(tbl_raddr), int'(vecs[n].ra));
      chk($sformatf("v%0d_we", n), int'(tbl_we), int'(vecs[n].we));
      if (vecs[n].we) begin
        chk($sformatf("v%0d_waddr", n), int'(tbl_waddr), int'(vecs[n].wa));
        chk($sformatf("v%0d_wdata", n), int'(tbl_wdata), int'(vecs[n].wd));
      end
      @(posedge clk); #1;
    end

    req0_valid = 1'b1; req0_idx = 8'd20; req0_taken = 1'b1;
    @(negedge clk);
    chk("mid_accept", int'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", int'(tbl_we), 0);
    chk("mid_rst_done", int'(init_done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sweep();

    req0_valid = 1'b1; req0_idx = 8'd3; req0_taken = 1'b1;
    req1_valid = 1'b1; req1_idx = 8'd4; req1_taken = 1'b1;
    @(negedge clk);
    chk("post_done", int'(init_done), 1);
    chk("post_rdy0", int'(req0_ready), 1);
    chk("post_rdy1", int'(req1_ready), 0);
    chk("post_we", int'(tbl_we), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("post_wr_we", int'(tbl_we), 1);
    chk("post_wr_waddr", int'(tbl_waddr), 3);
    chk("post_wr_wdata", int'(tbl_wdata), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bht_update_ctrl.md
# bht_update_ctrl

Update controller for the branch-history counter table. It accepts counter-update requests from two resolve sources and arbitrates between them round-robin. Each accepted request becomes a read-modify-write of a saturating counter on the table's single write port, with same-index forwarding. After reset it sweeps the whole table to the init value before it accepts any traffic.

## Interface
Parameters:
- ADDR_W, 8, index width
- DEPTH, 256, table entries (2^ADDR_W)
- CNT_W, 2, counter width
- INIT_VAL, 1, counter value written during the init sweep (weakly not-taken)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req0_valid  in  1  update request, source 0
- req0_ready  out  1  request 0 accepted this cycle
- req0_idx  in  ADDR_W  table index
- req0_taken  in  1  resolved direction
- req1_valid, req1_ready, req1_idx, req1_taken  same as source 0, for source 1
- tbl_raddr  out  ADDR_W  read address to the table's dedicated update read port
- tbl_rdata  in  CNT_W  combinational read data for tbl_raddr
- tbl_we  out  1  table write enable
- tbl_waddr  out  ADDR_W  write index
- tbl_wdata  out  CNT_W  write data
- init_done  out  1  high once the sweep is complete

## Operation
- States are INIT and RUN. Reset enters INIT with sweep counter 0, S1 invalid and rr_last = 1, so source 0 is favoured first.
- INIT behaviour:
  - Each cycle with reset low, drive tbl_we=1, tbl_waddr=cnt, tbl_wdata=INIT_VAL, then increment cnt.
  - At the edge that writes DEPTH-1, go to RUN.
  - Both readys are 0 throughout INIT.
- RUN arbitration:
  - If only one source is valid, grant it.
  - If both are valid, grant the source other than rr_last.
  - rr_last updates only on a grant.
  - reqN_ready = grant N. This is combinational from the valids and rr_last, with no valid-on-ready dependency.
- Stage 0, the accept cycle:
  - tbl_raddr = granted idx. When idle, tbl_raddr = req0_idx.
  - old = (S1 valid and S1 addr == granted idx) ? S1 data : tbl_rdata. This is the forwarding path.
  - new = taken ? (old == 2^CNT_W-1 ? old : old+1) : (old == 0 ? 0 : old-1).
  - Register {1, idx, new} into S1.
- Stage 1: tbl_we = S1 valid, tbl_waddr = S1 addr, tbl_wdata = S1 data. S1 clears when no grant occurs.
- Throughput is one update per cycle, sustained.
- Reset mid-operation:
  - An S1 write pending at the reset edge is dropped. tbl_we is gated with ~reset.
  - The sweep restarts from index 0.

## Timing
- Reset values: tbl_we=0, tbl_waddr=0, tbl_wdata=0, init_done=0, req0_ready=req1_ready=0.
- While reset is held high, tbl_we=0 and the controller stays in INIT with cnt=0.
- Sweep timing, counting the first cycle with reset low as cycle 0:
  - Write to entry k occurs in cycle k.
  - init_done=1 and readys are enabled from cycle DEPTH.
- Update latency: accept in cycle N, tbl_we=1 in cycle N+1, table updated at the end of N+1.
- Back-to-back accepts to the same index in N and N+1: the second update uses the forwarded value from N. There is no bubble and no lost update.
- The counter is CNT_W bits and never wraps: it saturates at 0 and at 2^CNT_W-1.

## Structure
- Shared package bp_pkg holds the CNT_W default, INIT_VAL, the state encoding and a sat_update(old, taken) function. The predictor lookup reuses sat_update.
- Natural sub-module: rr_arb2. Inputs are two valids and rr_last; outputs are two one-hot grants, with rr_last registered inside it.
- The remainder is the sweep counter, the S1 register and the forwarding compare, all in bht_update_ctrl.

## Test plan
- Init sweep: reset 2 cycles then release. Expect DEPTH writes of value 1 at indices 0..255, one per cycle, then init_done=1 at cycle 256 and no readys before it.
- Increment: after init, req0 idx=5 taken=1. Expect next cycle tbl_we=1, waddr=5, wdata=2. Three more taken requests give 3, 3, 3 (saturated).
- Decrement to floor: idx=9 at 1, two not-taken requests. Expect wdata 0, then 0.
- Forwarding: idx=7 taken in consecutive cycles N and N+1, starting from 1. Expect wdata 2 at N+1 and 3 at N+2.
- Arbitration: both valid continuously, idx0=3 and idx1=4, both taken. Expect grants 0,1,0,1…; req1 alone is granted immediately.
- Reset mid-run: assert reset in the cycle S1 holds a write. Expect no tbl_we in that cycle, the sweep restarting at 0, and init_done low until it completes.
